reg_file_wb: RTL and testbench

//  MIPS general-purpose register file (32 x DATA_W) fed by the write-back data mux.
//  - Consumes the selected write-back word: PC link value or the normal register result.
//  - Serves the two ID-stage operand reads (rs, rt) plus one debug read port.
//  - Internal write-to-read bypass: ID reads a register in the same cycle WB writes it,

---
 rtl/reg_file_wb.sv | 55 +++++
 tb/tb_reg_file_wb.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/reg_file_wb.sv
// MIPS 32-entry register file with write-back link select, same-cycle write-first
// bypass on the two ID read ports, an unbypassed debug port and a saturating write counter.
module reg_file_wb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LINK_REG = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write,
  input  logic              link_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [DATA_W-1:0] dbg_data,
  output logic [15:0]       wr_count
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [ADDR_W-1:0] eff_addr;
  logic              eff_we;

  // A link write-back always lands in LINK_REG; reset also suppresses the bypass.
  assign eff_addr = link_en ? ADDR_W'(LINK_REG) : wr_addr;
  assign eff_we   = reg_write & (eff_addr != '0) & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      wr_count <= '0;
    end else if (eff_we) begin
      regs[eff_addr] <= wr_data;
      if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
    end
  end

  // Write-first read: wr_data is only selected when a real write is in flight,
  // so an undriven wr_data on idle cycles never reaches the outputs.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    if (addr == '0)                      return '0;
    else if (eff_we && addr == eff_addr) return wr_data;
    else                                 return regs[addr];
  endfunction

  assign rd_data_a = read_port(rd_addr_a);
  assign rd_data_b = read_port(rd_addr_b);
  assign dbg_data  = regs[dbg_addr];

endmodule

// File: tb/tb_reg_file_wb.sv
// Self-checking bench for reg_file_wb: directed cases plus randomized write-back
// traffic checked against an array-based reference model of the register file.
module tb_reg_file_wb;

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_write;
  logic        link_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic [4:0]  dbg_addr;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic [31:0] dbg_data;
  logic [15:0] wr_count;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_regs [32];
  int          model_count;

  reg_file_wb #(.DATA_W(32), .ADDR_W(5), .LINK_REG(31)) dut (
    .clk       (clk),
    .reset     (reset),
    .reg_write (reg_write),
    .link_en   (link_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .dbg_addr  (dbg_addr),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .dbg_data  (dbg_data),
    .wr_count  (wr_count)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model
  function automatic logic [4:0] model_dest();
    return link_en ? 5'd31 : wr_addr;
  endfunction

  function automatic bit model_writes();
    return reg_write && !reset && model_dest() != 5'd0;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (model_writes() && model_dest() == a) return wr_data;
    return model_regs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
    model_count = 0;
  endtask

  task automatic check_outputs();
    exp_q.push_back(model_read(rd_addr_a));
    exp_q.push_back(model_read(rd_addr_b));
    exp_q.push_back(model_regs[dbg_addr]);
    exp_q.push_back(32'(model_count));
    check("rd_data_a", rd_data_a, exp_q.pop_front());
    check("rd_data_b", rd_data_b, exp_q.pop_front());
    check("dbg_data",  dbg_data,  exp_q.pop_front());
    check("wr_count",  {16'h0, wr_count}, exp_q.pop_front());
  endtask

  // driver: present one write-back/read set, check mid-cycle, commit at posedge
  task automatic cycle(input bit we, input bit link, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] ra,
                       input logic [4:0] rb, input logic [4:0] da, input bit chk);
    reg_write = we; link_en = link; wr_addr = wa; wr_data = wd;
    rd_addr_a = ra; rd_addr_b = rb; dbg_addr = da;
    @(negedge clk);
    if (chk) check_outputs();
    @(posedge clk);
    if (model_writes()) begin
      model_regs[model_dest()] = wr_data;
      if (model_count < 65535) model_count++;
    end
    #1;
  endtask

  task automatic random_cycle(input bit chk);
    logic [4:0]  wa, ra, rb, ea;
    bit          we, link;
    we   = ($urandom_range(0, 3) != 0);
    link = ($urandom_range(0, 7) == 0);
    wa   = 5'($urandom_range(0, 31));
    ea   = link ? 5'd31 : wa;
    ra   = ($urandom_range(0, 2) == 0) ? ea : 5'($urandom_range(0, 31));
    rb   = ($urandom_range(0, 2) == 0) ? ea : 5'($urandom_range(0, 31));
    cycle(we, link, wa, $urandom, ra, rb, 5'($urandom_range(0, 31)), chk);
  endtask

  initial begin
    // reset held: writes and bypass suppressed, everything reads zero
    reset = 1'b1; reg_write = 1'b0; link_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr_a = '0; rd_addr_b = '0; dbg_addr = '0;
    model_reset();
    @(posedge clk); #1;
    cycle(1, 0, 5'd4, 32'hCAFEF00D, 5'd4, 5'd4, 5'd4, 1);
    cycle(1, 1, 5'd2, 32'h0BADF00D, 5'd31, 5'd2, 5'd31, 1);
    reset = 1'b0;

    // T2 write then read next cycle
    cycle(1, 0, 5'd7, 32'h12345678, 5'd7, 5'd0, 5'd7, 1);
    cycle(0, 0, 5'd0, 32'h0, 5'd7, 5'd7, 5'd7, 1);
    check("t2_count", {16'h0, wr_count}, 32'd1);

    // T3 dual bypass, debug port sees old value
    cycle(1, 0, 5'd9, 32'h11112222, 5'd0, 5'd0, 5'd9, 0);
    cycle(1, 0, 5'd9, 32'hA5A5A5A5, 5'd9, 5'd9, 5'd9, 1);
    cycle(0, 0, 5'd0, 32'h0, 5'd9, 5'd9, 5'd9, 1);

    // T4 writes to r0 are dropped, uncounted, never bypassed
    cycle(1, 0, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0, 1);
    cycle(0, 0, 5'd0, 32'h0, 5'd0, 5'd9, 5'd0, 1);

    // T5 link forces r31; then same with reg_write=0; then link with wr_addr=0
    cycle(1, 1, 5'd3, 32'h00400008, 5'd31, 5'd3, 5'd31, 1);
    cycle(0, 1, 5'd3, 32'h00500000, 5'd31, 5'd3, 5'd3, 1);
    cycle(1, 1, 5'd0, 32'h00400010, 5'd31, 5'd0, 5'd31, 1);
    cycle(0, 0, 5'd0, 32'h0, 5'd31, 5'd3, 5'd31, 1);

    // T1 asynchronous reset mid-cycle, then a write on the following edge
    cycle(1, 0, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 5'd5, 1);
    reg_write = 1'b0; rd_addr_a = 5'd5; rd_addr_b = 5'd31; dbg_addr = 5'd5;
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    check("t1_rd_a", rd_data_a, 32'h0);
    check("t1_rd_b", rd_data_b, 32'h0);
    check("t1_dbg",  dbg_data,  32'h0);
    check("t1_count", {16'h0, wr_count}, 32'h0);
    #1;
    reset = 1'b0;
    cycle(1, 0, 5'd5, 32'h00000011, 5'd5, 5'd0, 5'd5, 1);
    cycle(0, 0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5, 1);

    // randomized traffic
    for (int i = 0; i < 2000; i++) random_cycle(1);

    // T6 saturation
    for (int i = 0; i < 65536; i++) begin
      cycle(1, 0, 5'($urandom_range(1, 31)), $urandom, 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            (i % 4096 == 0) || (model_count >= 65530 && model_count < 65535));
    end
    check("t6_sat", {16'h0, wr_count}, 32'h0000FFFF);
    for (int i = 0; i < 8; i++) cycle(1, 0, 5'd12, $urandom, 5'd12, 5'd1, 5'd12, 1);
    check("t6_hold", {16'h0, wr_count}, 32'h0000FFFF);
    for (int i = 0; i < 100; i++) random_cycle(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
